// File: rtl/req_gnt_responder.sv
// Single-initiator request/grant responder. It grants on the rising edge of req, limits the hold time and applies a cooldown.
// Define REQ_GNT_RESPONDER_ASSERT_EN to compile in the protocol assertions.
module req_gnt_responder #(
  parameter int HOLD_MAX = 8,
  parameter int COOLDOWN = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        gnt,
  output logic        busy,
  output logic [15:0] grant_cnt,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GRANT    = 2'd1;
  localparam logic [1:0] COOL     = 2'd2;
  localparam logic [1:0] WAIT_LOW = 2'd3;

  // The counters hold the number of cycles already completed in the state, so the last cycle is N-1.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN - 1);
  localparam logic [1:0] REL_STATE = (COOLDOWN == 0) ? IDLE : COOL;

  logic [1:0]  state, state_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic [7:0]  cool_cnt, cool_nxt;
  logic [15:0] cnt_q;
  logic        req_d;
  logic        gnt_nxt, terr_nxt, cnt_inc;
  logic        rise;

  assign rise      = req & ~req_d;
  assign grant_cnt = cnt_q;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    cool_nxt  = cool_cnt;
    gnt_nxt   = 1'b0;
    terr_nxt  = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = GRANT;
          gnt_nxt   = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      GRANT: begin
        // A falling req wins over hold expiry, so this case is a normal release.
        if (!req) begin
          state_nxt = REL_STATE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = WAIT_LOW;
          terr_nxt  = 1'b1;
        end else begin
          gnt_nxt  = 1'b1;
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      WAIT_LOW: begin
        if (!req) state_nxt = REL_STATE;
      end
      COOL: begin
        if (cool_cnt == COOL_LAST) state_nxt = IDLE;
        else                       cool_nxt  = cool_cnt + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) begin
      hold_nxt = 8'd0;
      cool_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= 8'd0;
      cool_cnt    <= 8'd0;
      req_d       <= 1'b0;
      gnt         <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      cool_cnt    <= cool_nxt;
      req_d       <= req;
      gnt         <= gnt_nxt;
      busy        <= (state_nxt != IDLE);
      timeout_err <= terr_nxt;
      if (cnt_inc && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

`ifdef REQ_GNT_RESPONDER_ASSERT_EN
  a_rise_grant: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE && req && !req_d) |=> gnt);
  a_gnt_state: assert property (@(posedge clk) disable iff (!rst_n)
    gnt |-> (state == GRANT));
  a_hold_max: assert property (@(posedge clk) disable iff (!rst_n)
    gnt [*HOLD_MAX] |=> !gnt);
  a_to_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    timeout_err |=> !timeout_err);
`endif

endmodule
